// File: rtl/laser_pkg.sv
// Shared definitions for the laser transmit and receive paths.
package laser_pkg;

    localparam int CLKS_PER_BIT_DEF = 8;
    localparam int PKT_BYTES_DEF    = 64;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/laser_bit_timer.sv
// Loadable down-counter; expire is high while running and the count has reached zero.
module laser_bit_timer #(
    parameter int W = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         run,
    output logic         expire
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (run && count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign expire = run && (count_reg == '0);

endmodule

// File: rtl/laser_rx_deframer.sv
// Oversampling UART-style deframer for the laser receive line, with a one-byte
// valid/ready holding register, per-packet byte count and error reporting.
module laser_rx_deframer
    import laser_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int PKT_BYTES    = PKT_BYTES_DEF,
    parameter int CT_W         = 10
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            en,
    input  logic            clear,
    input  logic            laser_rx,
    input  logic            data_ready,
    output logic [7:0]      data_out,
    output logic            data_valid,
    output logic [CT_W-1:0] byte_ct,
    output logic            pkt_done,
    output logic            overrun,
    output logic [7:0]      frame_err_ct,
    output logic            busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]   HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0]   FULL_LOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [CT_W-1:0] CT_MAX    = CT_W'(PKT_BYTES);

    logic            rx_m_reg, rx_s_reg;
    rx_state_t       state_reg;
    logic [2:0]      bit_idx_reg;
    logic [7:0]      shift_reg;
    logic [7:0]      data_out_reg;
    logic            data_valid_reg;
    logic [CT_W-1:0] byte_ct_reg;
    logic            overrun_reg;
    logic [7:0]      frame_err_ct_reg;

    logic            timer_load, timer_run, timer_expire;
    logic [TW-1:0]   timer_val;
    logic            stop_sample, accept, drop, stop_bad;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_m_reg <= 1'b1;
            rx_s_reg <= 1'b1;
        end else begin
            rx_m_reg <= laser_rx;
            rx_s_reg <= rx_m_reg;
        end
    end

    always_comb begin
        timer_load = 1'b0;
        timer_val  = FULL_LOAD;
        case (state_reg)
            IDLE: if (en && !rx_s_reg) begin
                timer_load = 1'b1;
                timer_val  = HALF_LOAD;
            end
            START:   timer_load = timer_expire && !rx_s_reg;
            DATA:    timer_load = timer_expire;
            default: timer_load = 1'b0;
        endcase
    end

    assign timer_run = (state_reg != IDLE);

    laser_bit_timer #(.W(TW)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .run      (timer_run),
        .expire   (timer_expire)
    );

    assign stop_sample = en && (state_reg == STOP) && timer_expire;
    assign accept      = stop_sample && rx_s_reg && (!data_valid_reg || data_ready);
    assign drop        = stop_sample && rx_s_reg && data_valid_reg && !data_ready;
    assign stop_bad    = stop_sample && !rx_s_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            bit_idx_reg <= 3'd0;
            shift_reg   <= 8'd0;
        end else if (!en) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE: if (!rx_s_reg) state_reg <= START;
                START: if (timer_expire) begin
                    bit_idx_reg <= 3'd0;
                    state_reg   <= rx_s_reg ? IDLE : DATA;
                end
                DATA: if (timer_expire) begin
                    shift_reg   <= {rx_s_reg, shift_reg[7:1]};
                    bit_idx_reg <= bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) state_reg <= STOP;
                end
                STOP: if (timer_expire) state_reg <= rx_s_reg ? IDLE : BREAK;
                BREAK: if (rx_s_reg) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_out_reg   <= 8'd0;
            data_valid_reg <= 1'b0;
        end else if (accept) begin
            data_out_reg   <= shift_reg;
            data_valid_reg <= 1'b1;
        end else if (data_valid_reg && data_ready) begin
            data_valid_reg <= 1'b0;
        end
    end

    // A clear coinciding with an event keeps that event rather than losing it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            byte_ct_reg      <= '0;
            overrun_reg      <= 1'b0;
            frame_err_ct_reg <= 8'd0;
        end else if (clear) begin
            byte_ct_reg      <= accept ? CT_W'(1) : '0;
            overrun_reg      <= drop;
            frame_err_ct_reg <= stop_bad ? 8'd1 : 8'd0;
        end else begin
            if (accept && byte_ct_reg != CT_MAX) byte_ct_reg <= byte_ct_reg + CT_W'(1);
            if (drop) overrun_reg <= 1'b1;
            if (stop_bad) frame_err_ct_reg <= sat_inc8(frame_err_ct_reg);
        end
    end

    assign data_out     = data_out_reg;
    assign data_valid   = data_valid_reg;
    assign byte_ct      = byte_ct_reg;
    assign pkt_done     = (byte_ct_reg == CT_MAX);
    assign overrun      = overrun_reg;
    assign frame_err_ct = frame_err_ct_reg;
    assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_laser_rx_deframer.sv
// Directed bench for laser_rx_deframer with CLKS_PER_BIT = 8 and PKT_BYTES = 4.
module tb_laser_rx_deframer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b1;
    logic       clear = 1'b0;
    logic       laser_rx = 1'b1;
    logic       data_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic [9:0] byte_ct;
    logic       pkt_done;
    logic       overrun;
    logic [7:0] frame_err_ct;
    logic       busy;

    laser_rx_deframer #(.CLKS_PER_BIT(8), .PKT_BYTES(4), .CT_W(10)) dut (
        .clock        (clock),
        .reset        (reset),
        .en           (en),
        .clear        (clear),
        .laser_rx     (laser_rx),
        .data_ready   (data_ready),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .byte_ct      (byte_ct),
        .pkt_done     (pkt_done),
        .overrun      (overrun),
        .frame_err_ct (frame_err_ct),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int frame_start = 0;
    int last_rise = -1;
    int valid_cycles = 0;
    logic dv_prev = 1'b0;
    logic [7:0] got[$];

    always @(posedge clock) cyc <= cyc + 1;

    // Records every handshake and the cycle each data_valid pulse begins.
    always @(negedge clock) begin
        if (data_valid && data_ready) got.push_back(data_out);
        if (data_valid) valid_cycles++;
        if (data_valid && !dv_prev) last_rise = cyc;
        dv_prev = data_valid;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic idle(input int n);
        laser_rx = 1'b1;
        step(n);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    // Cycle c of the frame starts just after edge c; the stop sample falls in cycle 78.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input bit clr_at_stop, input bit pop_at_stop, input bit en_drop);
        logic rdy_save;
        int k;
        rdy_save = data_ready;
        @(posedge clock);
        #1;
        frame_start = cyc;
        for (int c = 0; c < 80; c++) begin
            k = c / 8;
            if (k == 0) laser_rx = 1'b0;
            else if (k == 9) laser_rx = stop_bit;
            else laser_rx = b[k-1];
            clear      = clr_at_stop && (c == 78);
            data_ready = (pop_at_stop && c == 78) ? 1'b1 : rdy_save;
            en         = !(en_drop && c >= 44 && c < 46);
            step(1);
        end
        clear      = 1'b0;
        data_ready = rdy_save;
        en         = 1'b1;
    endtask

    task automatic test_reset();
        step(3);
        if (data_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", data_valid); end checks++;
        if (data_out !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", data_out); end checks++;
        if (byte_ct !== 10'd0) begin fails++; $display("FAIL reset_byte_ct: got %0d want 0", byte_ct); end checks++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end checks++;
        reset = 1'b1;
        step(3);
        if (busy !== 1'b0 || overrun !== 1'b0 || pkt_done !== 1'b0 || frame_err_ct !== 8'd0) begin
            fails++; $display("FAIL post_reset_flags: busy=%b ovr=%b pkt=%b ferr=%0d want all 0", busy, overrun, pkt_done, frame_err_ct);
        end checks++;
        $display("test_reset done");
    endtask

    task automatic test_clean();
        data_ready = 1'b1;
        pulse_clear();
        got.delete();
        valid_cycles = 0;
        send_frame(8'hA5, 1'b1, 0, 0, 0);
        idle(4);
        if (last_rise - frame_start !== 79) begin fails++; $display("FAIL clean_latency: got %0d want 79", last_rise - frame_start); end checks++;
        if (got.size() !== 1) begin fails++; $display("FAIL clean_count: got %0d want 1", got.size()); end checks++;
        if ((got.size() > 0 ? got[0] : 8'hxx) !== 8'hA5) begin fails++; $display("FAIL clean_data: got %h want a5", got.size() > 0 ? got[0] : 8'hxx); end checks++;
        if (valid_cycles !== 1) begin fails++; $display("FAIL clean_pulse_width: got %0d want 1", valid_cycles); end checks++;
        if (byte_ct !== 10'd1) begin fails++; $display("FAIL clean_byte_ct: got %0d want 1", byte_ct); end checks++;
        if (frame_err_ct !== 8'd0) begin fails++; $display("FAIL clean_ferr: got %0d want 0", frame_err_ct); end checks++;
        $display("test_clean: byte a5 received");
    endtask

    task automatic test_back_to_back();
        data_ready = 1'b0;
        pulse_clear();
        got.delete();
        send_frame(8'h3C, 1'b1, 0, 0, 0);
        idle(4);
        send_frame(8'hC3, 1'b1, 0, 0, 0);
        idle(4);
        if (data_valid !== 1'b1) begin fails++; $display("FAIL bp_valid: got %b want 1", data_valid); end checks++;
        if (data_out !== 8'h3C) begin fails++; $display("FAIL bp_hold: got %h want 3c", data_out); end checks++;
        if (overrun !== 1'b1) begin fails++; $display("FAIL bp_overrun: got %b want 1", overrun); end checks++;
        if (byte_ct !== 10'd1) begin fails++; $display("FAIL bp_byte_ct: got %0d want 1", byte_ct); end checks++;
        data_ready = 1'b1;
        step(1);
        if (data_valid !== 1'b0) begin fails++; $display("FAIL bp_pop_fall: got %b want 0", data_valid); end checks++;
        idle(20);
        if (got.size() !== 1) begin fails++; $display("FAIL bp_pop_count: got %0d want 1", got.size()); end checks++;
        $display("test_back_to_back: 3c held, c3 dropped");
    endtask

    task automatic test_glitch_framing();
        data_ready = 1'b1;
        pulse_clear();
        valid_cycles = 0;
        laser_rx = 1'b0;
        step(3);
        laser_rx = 1'b1;
        step(1);
        if (busy !== 1'b1) begin fails++; $display("FAIL glitch_busy: got %b want 1", busy); end checks++;
        idle(20);
        if (busy !== 1'b0) begin fails++; $display("FAIL glitch_idle: got %b want 0", busy); end checks++;
        if (frame_err_ct !== 8'd0) begin fails++; $display("FAIL glitch_ferr: got %0d want 0", frame_err_ct); end checks++;
        send_frame(8'h55, 1'b0, 0, 0, 0);
        step(10);
        if (frame_err_ct !== 8'd1) begin fails++; $display("FAIL frame_ferr: got %0d want 1", frame_err_ct); end checks++;
        if (busy !== 1'b1) begin fails++; $display("FAIL frame_break_busy: got %b want 1", busy); end checks++;
        idle(6);
        if (busy !== 1'b0) begin fails++; $display("FAIL frame_break_exit: got %b want 0", busy); end checks++;
        if (valid_cycles !== 0) begin fails++; $display("FAIL frame_no_output: got %0d want 0", valid_cycles); end checks++;
        $display("test_glitch_framing: glitch ignored, bad stop counted");
    endtask

    task automatic test_packet();
        logic [9:0] exp_ct;
        data_ready = 1'b1;
        pulse_clear();
        got.delete();
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, 0, 0, 0);
            idle(4);
            exp_ct = (i > 4) ? 10'd4 : 10'(i);
            if (byte_ct !== exp_ct) begin fails++; $display("FAIL pkt_byte_ct_%0d: got %0d want %0d", i, byte_ct, exp_ct); end checks++;
            if (pkt_done !== (i >= 4)) begin fails++; $display("FAIL pkt_done_%0d: got %b want %b", i, pkt_done, i >= 4); end checks++;
        end
        if (got.size() !== 5) begin fails++; $display("FAIL pkt_count: got %0d want 5", got.size()); end checks++;
        for (int i = 0; i < got.size(); i++) begin
            if (got[i] !== 8'(i + 1)) begin fails++; $display("FAIL pkt_order_%0d: got %h want %h", i, got[i], 8'(i + 1)); end checks++;
        end
        pulse_clear();
        if (byte_ct !== 10'd0 || pkt_done !== 1'b0) begin fails++; $display("FAIL pkt_clear: byte_ct=%0d pkt_done=%b want 0 0", byte_ct, pkt_done); end checks++;
        $display("test_packet: 5 bytes, count saturated at 4");
    endtask

    task automatic test_simultaneous();
        data_ready = 1'b1;
        pulse_clear();
        send_frame(8'h66, 1'b1, 0, 0, 0);
        idle(4);
        send_frame(8'h99, 1'b1, 1, 0, 0);
        idle(4);
        if (byte_ct !== 10'd1) begin fails++; $display("FAIL clear_at_stop: got %0d want 1", byte_ct); end checks++;
        data_ready = 1'b0;
        pulse_clear();
        got.delete();
        send_frame(8'h11, 1'b1, 0, 0, 0);
        idle(4);
        send_frame(8'h22, 1'b1, 0, 1, 0);
        idle(2);
        if (data_out !== 8'h22 || data_valid !== 1'b1) begin fails++; $display("FAIL pop_at_stop_data: got %h/%b want 22/1", data_out, data_valid); end checks++;
        if (overrun !== 1'b0) begin fails++; $display("FAIL pop_at_stop_overrun: got %b want 0", overrun); end checks++;
        if (byte_ct !== 10'd2) begin fails++; $display("FAIL pop_at_stop_ct: got %0d want 2", byte_ct); end checks++;
        if (got.size() !== 1 || (got.size() > 0 ? got[0] : 8'hxx) !== 8'h11) begin fails++; $display("FAIL pop_at_stop_popped: got %0d entries want one 11", got.size()); end checks++;
        data_ready = 1'b1;
        idle(4);
        $display("test_simultaneous: clear and pop at stop sample");
    endtask

    task automatic test_abort();
        data_ready = 1'b1;
        pulse_clear();
        got.delete();
        send_frame(8'hFF, 1'b1, 0, 0, 1);
        idle(10);
        send_frame(8'h12, 1'b1, 0, 0, 0);
        idle(4);
        if (got.size() !== 1 || (got.size() > 0 ? got[0] : 8'hxx) !== 8'h12) begin fails++; $display("FAIL abort_only_12: got %0d entries want one 12", got.size()); end checks++;
        if (frame_err_ct !== 8'd0) begin fails++; $display("FAIL abort_ferr: got %0d want 0", frame_err_ct); end checks++;
        if (byte_ct !== 10'd1) begin fails++; $display("FAIL abort_byte_ct: got %0d want 1", byte_ct); end checks++;
        data_ready = 1'b0;
        send_frame(8'h77, 1'b1, 0, 0, 0);
        idle(4);
        laser_rx = 1'b0;
        step(30);
        if (busy !== 1'b1 || data_valid !== 1'b1) begin fails++; $display("FAIL pre_reset_state: busy=%b valid=%b want 1 1", busy, data_valid); end checks++;
        #2;
        reset = 1'b0;
        #1;
        if (data_valid !== 1'b0 || data_out !== 8'h00 || byte_ct !== 10'd0 || busy !== 1'b0) begin
            fails++; $display("FAIL async_reset: valid=%b data=%h ct=%0d busy=%b want all 0", data_valid, data_out, byte_ct, busy);
        end checks++;
        valid_cycles = 0;
        step(20);
        laser_rx = 1'b1;
        reset = 1'b1;
        idle(100);
        if (valid_cycles !== 0) begin fails++; $display("FAIL reset_partial_frame: got %0d valid cycles want 0", valid_cycles); end checks++;
        $display("test_abort: en drop and reset discard partial frames");
    endtask

    initial begin
        test_reset();
        test_clean();
        test_back_to_back();
        test_glitch_framing();
        test_packet();
        test_simultaneous();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/laser_rx_deframer.md
Name: laser_rx_deframer

Overview:
- Receive-side counterpart to the laser transmit path. Oversamples one laser_rx line, recovers UART-style frames (start, 8 data bits LSB-first, stop) and presents bytes on a valid/ready handshake.
- Counts accepted bytes per packet so the consumer (FTDI write path or echo logic) knows when a full PKT_BYTES packet has arrived.
- Sits between the laser photodiode input pin and the byte queue feeding the FTDI interface.

Parameters:
- CLKS_PER_BIT, 8: clock cycles per laser bit. Even, >= 4.
- PKT_BYTES, 64: bytes per packet. Sets the pkt_done threshold.
- CT_W, 10: width of byte_ct. Must satisfy 2^CT_W > PKT_BYTES.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- en, input, 1: receive enable. When low, the FSM is held in IDLE.
- clear, input, 1: synchronous clear of byte_ct, overrun and frame_err_ct.
- laser_rx, input, 1: raw laser line, asynchronous to clock. Idles high.
- data_ready, input, 1: consumer accepts data_out this cycle.
- data_out, output, 8: received byte.
- data_valid, output, 1: data_out holds an unconsumed byte.
- byte_ct, output, CT_W: bytes accepted into the holding register since the last clear.
- pkt_done, output, 1: byte_ct == PKT_BYTES (level).
- overrun, output, 1: sticky. A completed byte was dropped because the holding register was full.
- frame_err_ct, output, 8: saturating count of bad stop bits.
- busy, output, 1: FSM is not in IDLE.

Behaviour:
- Reset: all outputs are 0. FSM = IDLE. Synchronizer flops reset to 1 (line idle).
- Input sync: laser_rx passes through a 2-flop synchronizer; rx_s is the second flop. Everything below acts on rx_s. t0 = first cycle rx_s == 0 while in IDLE with en = 1.
- FSM states:
  - IDLE: rx_s == 0 && en -> START. Load bit timer with CLKS_PER_BIT/2 - 1.
  - START: when the timer expires (t0 + CLKS_PER_BIT/2), sample rx_s.
    - rx_s == 0 -> DATA, bit_idx = 0, timer = CLKS_PER_BIT - 1.
    - rx_s == 1 -> IDLE (glitch). Not counted as an error.
  - DATA: on each timer expiry, shift rx_s into the shift register MSB, so bit 0 lands first and ends up as the LSB.
    - Bit i is sampled at t0 + CLKS_PER_BIT/2 + (i+1)*CLKS_PER_BIT.
    - After bit 7 -> STOP.
  - STOP: sample at t0 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT.
    - rx_s == 1 -> deliver the byte, then IDLE.
    - rx_s == 0 -> frame_err_ct += 1 (saturating at 255), byte discarded, then BREAK.
  - BREAK: wait for rx_s == 1, then IDLE.
- Delivery, evaluated in the stop-sample cycle:
  - Holding register empty, or data_ready in that same cycle: data_out/data_valid update on the next edge. data_valid latency = stop sample + 1 cycle. byte_ct += 1.
  - Holding register full and no data_ready: byte dropped, overrun <= 1, byte_ct unchanged.
- Handshake:
  - data_valid stays high and data_out stays stable until data_valid && data_ready.
  - Pop with no new byte arriving: data_valid falls on the next edge.
- byte_ct and pkt_done:
  - byte_ct saturates at PKT_BYTES; pkt_done stays high.
  - Bytes that arrive after pkt_done are still delivered, but byte_ct does not advance.
- clear:
  - byte_ct <= 0, overrun <= 0, frame_err_ct <= 0.
  - Does not touch the FSM or the holding register.
  - clear and a delivery in the same cycle -> byte_ct = 1.
- en deassert mid-frame: FSM -> IDLE on the next edge. The partial byte is discarded and not counted as an error. The holding register is kept.
- Reset mid-frame: immediate return to the reset state. A partial frame yields no output.

Decomposition:
- Shared package laser_pkg:
  - rx_state_t enum (IDLE, START, DATA, STOP, BREAK).
  - Default CLKS_PER_BIT and PKT_BYTES constants, shared with the laser transmitter.
- One natural sub-module: laser_bit_timer. A down-counter with load value, enable and an expire pulse. The transmitter reuses it.
- Reuse the existing Counter for byte_ct.

Test Plan (CLKS_PER_BIT = 8, PKT_BYTES = 4):
- Clean frame: send 0xA5 with data_ready = 1. Expect data_valid for 1 cycle at t0 + 77 with data_out = 0xA5, byte_ct = 1, frame_err_ct = 0.
- Back-pressure: data_ready = 0, send 0x3C then 0xC3. Expect data_out to hold 0x3C, overrun = 1, byte_ct = 1. Then raise data_ready: data_valid falls next cycle and 0xC3 never appears.
- Glitch and framing: a 3-cycle low pulse returns to IDLE with no output and frame_err_ct = 0. A frame sending 0x55 with stop = 0 gives frame_err_ct = 1, no data_valid, and busy until the line returns high.
- Packet: send 0x01..0x05. Expect pkt_done high after the 4th byte, byte_ct = 4 (saturated), and all 5 bytes delivered in order. Then pulse clear with no simultaneous delivery: byte_ct = 0, pkt_done = 0.
- Simultaneous events: clear in the cycle that the stop bit is sampled -> byte_ct = 1. Pop in the stop-sample cycle while full -> new byte delivered, no overrun.
- Abort: drop en at bit 4 of 0xFF, raise it again, send 0x12. Expect only 0x12 delivered and frame_err_ct = 0. Assert reset (low) mid-frame: all outputs are 0 immediately.
